// File: rtl/db_sw_top.sv
// Switch-debounce demonstrator: sync + debounce two buttons, count raw vs debounced falls, show on 7-seg.
// Latency: 2-cycle synchronizer, DB_CYCLES debounce window, count 1 cycle after edge, display 1 cycle after count.
// Backpressure: none; free-running datapath, buttons sampled every cycle.

module db_sw_diff_ibuf (
    input  logic pad_p,
    input  logic pad_n,
    output logic clk
);
    assign clk = pad_p & ~pad_n;
endmodule

module db_sw_top #(
    parameter int CLK_FREQ   = 200_000_000,
    parameter int DB_TIME_MS = 20,
    parameter int SCAN_DIV   = CLK_FREQ / 4000
) (
    input  logic       sys_clk_p,
    input  logic       sys_clk_n,
    input  logic       sys_rstn,
    input  logic [1:0] button,
    output logic [3:0] seg_sel,
    output logic [7:0] seg_led
);
    localparam int DB_CYCLES = CLK_FREQ / 1000 * DB_TIME_MS;
    localparam int DB_W      = $clog2(DB_CYCLES + 1);
    localparam int SCAN_W    = $clog2(SCAN_DIV + 1);

    typedef struct packed {
        logic [7:0] raw;
        logic [7:0] dbn;
    } cnt_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      sync_meta;
    logic [1:0]      sync;
    logic [1:0]      db;
    logic [DB_W-1:0] db_run [2];
    logic            sync1_d;
    logic            db1_d;
    logic            raw_fall;
    logic            db_fall;
    cnt_t            cnt;

    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tick;
    logic [1:0]        digit_idx;
    logic [1:0]        next_idx;
    logic [3:0]        nibble;

    db_sw_diff_ibuf u_clk_ibuf (
        .pad_p (sys_clk_p),
        .pad_n (sys_clk_n),
        .clk   (clk)
    );

    assign rst_n = sys_rstn;

    // Released level (1) out of reset so an idle button never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 2'b11;
            sync      <= 2'b11;
        end else begin
            sync_meta <= button;
            sync      <= sync_meta;
        end
    end

    // db only follows sync after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db        <= 2'b11;
            db_run[0] <= '0;
            db_run[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == db[i]) begin
                    db_run[i] <= '0;
                end else if (db_run[i] == DB_W'(DB_CYCLES - 1)) begin
                    db[i]     <= sync[i];
                    db_run[i] <= '0;
                end else begin
                    db_run[i] <= db_run[i] + DB_W'(1);
                end
            end
        end
    end

    assign raw_fall = sync1_d & ~sync[1];
    assign db_fall  = db1_d & ~db[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_d <= 1'b1;
            db1_d   <= 1'b1;
            cnt     <= '0;
        end else begin
            sync1_d <= sync[1];
            db1_d   <= db[1];
            if (!db[0]) begin
                cnt <= '0;
            end else begin
                if (raw_fall) cnt.raw <= cnt.raw + 8'd1;
                if (db_fall)  cnt.dbn <= cnt.dbn + 8'd1;
            end
        end
    end

    assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign next_idx  = scan_tick ? digit_idx + 2'd1 : digit_idx;

    always_comb begin
        nibble = cnt.dbn[3:0];
        case (next_idx)
            2'd0:    nibble = cnt.dbn[3:0];
            2'd1:    nibble = cnt.dbn[7:4];
            2'd2:    nibble = cnt.raw[3:0];
            default: nibble = cnt.raw[7:4];
        endcase
    end

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 8'hC0;
            4'h1:    hex7 = 8'hF9;
            4'h2:    hex7 = 8'hA4;
            4'h3:    hex7 = 8'hB0;
            4'h4:    hex7 = 8'h99;
            4'h5:    hex7 = 8'h92;
            4'h6:    hex7 = 8'h82;
            4'h7:    hex7 = 8'hF8;
            4'h8:    hex7 = 8'h80;
            4'h9:    hex7 = 8'h90;
            4'hA:    hex7 = 8'h88;
            4'hB:    hex7 = 8'h83;
            4'hC:    hex7 = 8'hC6;
            4'hD:    hex7 = 8'hA1;
            4'hE:    hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    // seg_led is computed from the index seg_sel is about to take, keeping the pair aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
            seg_sel   <= 4'b1110;
            seg_led   <= 8'hC0;
        end else begin
            scan_cnt  <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
            digit_idx <= next_idx;
            seg_sel   <= ~(4'b0001 << next_idx);
            seg_led   <= hex7(nibble);
        end
    end

endmodule

// File: tb/tb_db_sw_top.sv
// Randomized and directed bench for db_sw_top with a cycle-level behavioural model.
// Uses a scaled clock frequency so debounce and scan windows stay short.

module tb_db_sw_top;
    localparam int CLK_FREQ   = 20000;
    localparam int DB_TIME_MS = 1;
    localparam int SCAN       = CLK_FREQ / 4000;
    localparam int DB         = CLK_FREQ / 1000 * DB_TIME_MS;

    logic       sys_clk_p = 1'b0;
    logic       sys_clk_n = 1'b1;
    logic       sys_rstn  = 1'b1;
    logic [1:0] button    = 2'b11;
    logic [3:0] seg_sel;
    logic [7:0] seg_led;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // model state
    int         m_edges = 0;
    logic [7:0] m_led   = 8'hC0;
    logic [7:0] m_raw   = 8'd0;
    logic [7:0] m_dbc   = 8'd0;
    logic [1:0] m_db    = 2'b11;
    logic       m_db1_prev = 1'b1;
    logic [1:0] b_d1 = 2'b11;
    logic [1:0] b_d2 = 2'b11;
    logic       b_d3 = 1'b1;
    int         run [2];

    db_sw_top #(
        .CLK_FREQ   (CLK_FREQ),
        .DB_TIME_MS (DB_TIME_MS),
        .SCAN_DIV   (SCAN)
    ) dut (
        .sys_clk_p (sys_clk_p),
        .sys_clk_n (sys_clk_n),
        .sys_rstn  (sys_rstn),
        .button    (button),
        .seg_sel   (seg_sel),
        .seg_led   (seg_led)
    );

    always #5 begin
        sys_clk_p = ~sys_clk_p;
        sys_clk_n = ~sys_clk_n;
    end

    // Behavioural model: button seen 2 edges late; db flips after DB disagreeing cycles;
    // counts follow falls of those levels; display index = (edges since reset / SCAN) mod 4.
    initial begin : model
        int         idx_next;
        logic [3:0] nib;
        bit         raw_fell, db_fell, clr;
        run[0] = 0;
        run[1] = 0;
        forever begin
            @(posedge sys_clk_p or negedge sys_rstn);
            if (!sys_rstn) begin
                m_edges = 0; m_led = 8'hC0; m_raw = 8'd0; m_dbc = 8'd0;
                m_db = 2'b11; m_db1_prev = 1'b1;
                b_d1 = 2'b11; b_d2 = 2'b11; b_d3 = 1'b1;
                run[0] = 0; run[1] = 0;
            end else begin
                idx_next = ((m_edges + 1) / SCAN) % 4;
                case (idx_next)
                    0:       nib = m_dbc[3:0];
                    1:       nib = m_dbc[7:4];
                    2:       nib = m_raw[3:0];
                    default: nib = m_raw[7:4];
                endcase
                m_led    = hex_tab[nib];
                raw_fell = b_d3 && !b_d2[1];
                db_fell  = m_db1_prev && !m_db[1];
                clr      = !m_db[0];
                m_db1_prev = m_db[1];
                for (int i = 0; i < 2; i++) begin
                    if (b_d2[i] != m_db[i]) begin
                        run[i]++;
                        if (run[i] == DB) begin
                            m_db[i] = b_d2[i];
                            run[i]  = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
                if (clr) begin
                    m_raw = 8'd0;
                    m_dbc = 8'd0;
                end else begin
                    if (raw_fell) m_raw = m_raw + 8'd1;
                    if (db_fell)  m_dbc = m_dbc + 8'd1;
                end
                b_d3 = b_d2[1];
                b_d2 = b_d1;
                b_d1 = button;
                m_edges++;
            end
        end
    end

    initial begin : compare
        logic [3:0] exp_sel;
        int         idx;
        forever begin
            @(negedge sys_clk_p);
            if (cmp_en) begin
                idx     = (m_edges / SCAN) % 4;
                exp_sel = ~(4'b0001 << idx);
                checks++;
                if (seg_sel !== exp_sel || seg_led !== m_led) begin
                    errors++;
                    $display("FAIL cycle_cmp t=%0t: seg_sel=%b seg_led=%h, expected %b %h",
                             $time, seg_sel, seg_led, exp_sel, m_led);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] b, input int cyc);
        button = b;
        repeat (cyc) @(negedge sys_clk_p);
    endtask

    task automatic check_val(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_digit(input int d, input logic [7:0] exp, input string nm);
        logic [3:0] want;
        bit         found;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        for (int k = 0; k < 4 * SCAN + 4; k++) begin
            @(negedge sys_clk_p);
            if (seg_sel === want) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: digit %0d never selected, seg_sel=%b", nm, d, seg_sel);
        end else begin
            check_val(nm, seg_led, exp);
        end
    endtask

    task automatic check_all(input logic [7:0] d3, input logic [7:0] d2,
                             input logic [7:0] d1, input logic [7:0] d0, input string nm);
        check_digit(0, d0, {nm, "_d0"});
        check_digit(1, d1, {nm, "_d1"});
        check_digit(2, d2, {nm, "_d2"});
        check_digit(3, d3, {nm, "_d3"});
    endtask

    initial begin : stim
        #1 sys_rstn = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge sys_clk_p);
        check_val("rst_sel", {4'b0, seg_sel}, 8'h0E);
        check_val("rst_led", seg_led, 8'hC0);
        sys_rstn = 1'b1;

        // Scan steps after SCAN edges.
        @(negedge sys_clk_p);
        check_val("scan_first", {4'b0, seg_sel}, 8'h0E);
        repeat (SCAN - 1) @(negedge sys_clk_p);
        check_val("scan_step", {4'b0, seg_sel}, 8'h0D);
        check_all(8'hC0, 8'hC0, 8'hC0, 8'hC0, "idle");

        // Clean press.
        drive(2'b01, 30);
        drive(2'b11, 30);
        check_val("clean_raw_m", m_raw, 8'd1);
        check_val("clean_db_m", m_dbc, 8'd1);
        check_all(8'hC0, 8'hF9, 8'hC0, 8'hF9, "clean");

        // Glitch shorter than the debounce window.
        drive(2'b01, 10);
        drive(2'b11, 30);
        check_val("glitch_raw_m", m_raw, 8'd2);
        check_all(8'hC0, 8'hA4, 8'hC0, 8'hF9, "glitch");

        // Long clear.
        drive(2'b10, 25);
        drive(2'b11, 30);
        check_val("clear_raw_m", m_raw, 8'd0);
        check_all(8'hC0, 8'hC0, 8'hC0, 8'hC0, "clear");

        // Bouncy press.
        drive(2'b01, 3);
        drive(2'b11, 3);
        drive(2'b01, 3);
        drive(2'b11, 3);
        drive(2'b01, 30);
        drive(2'b11, 30);
        check_val("bounce_raw_m", m_raw, 8'd3);
        check_val("bounce_db_m", m_dbc, 8'd1);
        check_all(8'hC0, 8'hB0, 8'hC0, 8'hF9, "bounce");

        // Short clear is filtered out.
        drive(2'b10, 10);
        drive(2'b11, 30);
        check_all(8'hC0, 8'hB0, 8'hC0, 8'hF9, "short_clr");

        // Random button activity; the per-cycle compare carries the checking.
        for (int r = 0; r < 150; r++)
            drive(2'($urandom_range(0, 3)), $urandom_range(1, 40));
        drive(2'b11, 50);

        // Wrap: clear, 255 presses to FF, then one more to 00.
        drive(2'b10, 25);
        drive(2'b11, 30);
        for (int p = 0; p < 255; p++) begin
            drive(2'b01, 30);
            drive(2'b11, 30);
        end
        check_val("ff_db_m", m_dbc, 8'hFF);
        check_all(8'h8E, 8'h8E, 8'h8E, 8'h8E, "ff");
        drive(2'b01, 30);
        drive(2'b11, 30);
        check_val("wrap_db_m", m_dbc, 8'h00);
        check_all(8'hC0, 8'hC0, 8'hC0, 8'hC0, "wrap");

        // Give the counts a nonzero value, then reset mid-press with button held through release.
        drive(2'b01, 30);
        drive(2'b11, 30);
        check_all(8'hC0, 8'hF9, 8'hC0, 8'hF9, "pre_rst");
        button = 2'b01;
        repeat (10) @(negedge sys_clk_p);
        repeat (SCAN) @(negedge sys_clk_p);
        #2 sys_rstn = 1'b0;
        #1;
        check_val("midrst_sel", {4'b0, seg_sel}, 8'h0E);
        check_val("midrst_led", seg_led, 8'hC0);
        repeat (5) @(negedge sys_clk_p);
        sys_rstn = 1'b1;
        drive(2'b01, 30);
        drive(2'b11, 30);
        check_val("held_raw_m", m_raw, 8'd1);
        check_val("held_db_m", m_dbc, 8'd1);
        check_all(8'hC0, 8'hF9, 8'hC0, 8'hF9, "held");

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/db_sw_top.md
Name: db_sw_top

Overview:
- Switch-debouncing demonstrator top level for the FPGA board.
- Two active-low push-buttons are synchronized and debounced.
- Falling edges of button[1] are counted twice: raw (synchronized only) and debounced.
- Both 8-bit counts appear in hex on a multiplexed 4-digit 7-segment display, showing the effect of bounce.

Parameters:
- CLK_FREQ, 200_000_000, input clock frequency in Hz; all timing is derived from it.
- DB_TIME_MS, 20, debounce stability window in ms; DB_CYCLES = CLK_FREQ/1000*DB_TIME_MS.
- SCAN_DIV, CLK_FREQ/4000, clock cycles each display digit is held.

Ports:
- sys_clk_p, input, 1, differential clock positive leg.
- sys_clk_n, input, 1, differential clock negative leg.
- sys_rstn, input, 1, asynchronous active-low reset.
- button, input, 2, active-low buttons: [1] count button, [0] clear button.
- seg_sel, output, 4, active-low digit enables; [0] is the rightmost digit.
- seg_led, output, 8, active-low segments {dp,g,f,e,d,c,b,a}.

Behaviour:
- Clocking and reset:
  - Interface: one clock; reset is asynchronous and active-low.
  - The differential pair goes through a differential input buffer into internal single-ended clock clk; all logic runs on posedge clk.
  - sys_rstn clears every register asynchronously; release is used directly.
- Synchronizer:
  - 2-flop synchronizer per button bit.
  - Synchronizer flops reset to 1 (released).
- Debouncer, per bit:
  - Debounced output db resets to 1.
  - A counter counts consecutive cycles in which the synchronized input differs from db.
  - When the count reaches DB_CYCLES, db takes the input value and the counter clears.
  - Any cycle where input equals db clears the counter, so pulses shorter than DB_CYCLES never change db.
- Edge detect:
  - raw_fall = synchronized button[1] went 1->0.
  - db_fall = db[1] went 1->0.
- Counters:
  - raw_cnt and db_cnt are 8-bit, reset to 0.
  - Each increments by 1 one cycle after its fall pulse; wraps 0xFF->0x00.
  - While db[0]==0, both counters are held at 0 (synchronous clear).
  - Clear beats a simultaneous increment.
- Display:
  - digit3 = raw_cnt[7:4], digit2 = raw_cnt[3:0], digit1 = db_cnt[7:4], digit0 = db_cnt[3:0].
  - A 2-bit digit index advances every SCAN_DIV cycles in order 0,1,2,3,0...
  - seg_sel is one-hot-low: 1110, 1101, 1011, 0111.
  - seg_led is registered and updates on the same edge as seg_sel, with the nibble of the selected digit.
  - dp is always 1 (off).
  - Hex encodings: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Reset values: seg_sel = 4'b1110, seg_led = 8'hC0, scan counter = 0.
- Reset asserted mid-operation: counts return to 0 and debounce state returns to released; no press is counted on release of reset.
- Buttons held low through reset release:
  - Synchronized value falls 1->0, so raw_cnt increments once.
  - db falls after DB_CYCLES, so db_cnt increments once.

Test Plan (all with CLK_FREQ=1_000_000, so DB_CYCLES=20000 and SCAN_DIV=250):
- Reset, buttons=11 -> seg_sel=1110 and seg_led=C0 during reset. After release, seg_sel steps 1110->1101->1011->0111 every 250 cycles with seg_led=C0 on every digit.
- Clean press: button=01 for 30000 cycles, then 11 -> raw_cnt=01, db_cnt=01. Digits 0 and 2 show F9, digits 1 and 3 show C0.
- Bouncy press: button[1] toggles low/high/low/high/low at 100-cycle intervals, then stays low 30000 cycles -> raw_cnt=03, db_cnt=01. Digit2 shows B0, digit0 shows F9.
- Glitch: button[1] low for 10000 cycles only -> raw_cnt +1, db_cnt unchanged.
- Clear: after counts are nonzero, button=10 for 25000 cycles -> both counts 00 and all digits C0. Holding it for only 10000 cycles leaves the counts unchanged.
- Wrap: 256 clean presses (30000 cycles low, 30000 high each) -> db_cnt back to 00. Asserting sys_rstn mid-press -> counts 00 immediately.
